// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// the configuration check, the derived stage count and the beat types.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CHUNK = 8;

    // A geometry is legal when the operand splits into whole, non-empty slices.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // One pipeline stage per slice.
    function automatic int calc_stages(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

    localparam int DEFAULT_STAGES = calc_stages(DEFAULT_WIDTH, DEFAULT_CHUNK);
    localparam bit DEFAULT_CFG_OK = width_ok(DEFAULT_WIDTH, DEFAULT_CHUNK);

    // Operand beat as it crosses the input handshake.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic                     c_in;
        logic                     sub;
    } in_beat_t;

    // Result beat as it crosses the output handshake.
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] sum;
        logic                     c_out;
        logic                     ovf;
    } out_beat_t;

endpackage

// File: rtl/pipe_adder_if.sv
// Operand and result channels of pipe_adder.
// Handshake: a beat moves on a channel in the cycle where valid && ready are
// both high at the rising clock edge. The producer holds valid and payload
// steady until the transfer; valid never depends on ready, while ready may
// depend combinationally on the downstream ready.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/pipe_adder_add_slice.sv
// CHUNK-bit combinational adder slice. Besides the carry out it reports the
// carry into its MSB so the top slice can derive signed overflow.
module add_slice
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] full;

    assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
    assign sum   = full[CHUNK-1:0];
    assign c_out = full[CHUNK];
    // The sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out of it.
    assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor. Stage k adds slice k using the
// carry registered by stage k-1; lower sum slices and untouched upper operand
// slices travel along with the beat. All outputs come straight from the last
// stage's registers.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_adder_if.slave  bus
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    // Per-stage state.
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [STAGES-1:0] c_r;
    logic              ovf_r;

    // Per-stage inputs and slice results.
    logic [STAGES-1:0] up_v;
    logic [STAGES:0]   rdy;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  nxt_a [STAGES];
    logic [CHUNK-1:0]  s_w   [STAGES];
    logic              co_w  [STAGES];
    logic              cm_w  [STAGES];

    // Select each stage's operands: stage 0 takes the bus (with b inverted and
    // carry forced for subtraction), later stages take the previous registers.
    always_comb begin
        src_c    = '0;
        up_v     = '0;
        src_a[0] = bus.a;
        src_b[0] = bus.sub ? ~bus.b : bus.b;
        src_c[0] = bus.sub ? 1'b1 : bus.c_in;
        up_v[0]  = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_r[k-1];
            src_b[k] = b_r[k-1];
            src_c[k] = c_r[k-1];
            up_v[k]  = v[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            add_slice #(.CHUNK(CHUNK)) u_slice (
                .a     (src_a[k][k*CHUNK +: CHUNK]),
                .b     (src_b[k][k*CHUNK +: CHUNK]),
                .c_in  (src_c[k]),
                .sum   (s_w[k]),
                .c_out (co_w[k]),
                .c_msb (cm_w[k])
            );
        end
    endgenerate

    // Overwrite slice k of the travelling word with the freshly computed sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_a[k] = src_a[k];
            nxt_a[k][k*CHUNK +: CHUNK] = s_w[k];
        end
    end

    // Ready chain from the output back to the input: a stage can take a beat
    // when it is empty or its occupant is leaving this cycle.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    assign bus.in_ready = rdy[0];

    // Stage registers: load whenever ready (bubbles collapse), hold otherwise.
    // Payload only moves with a real beat so idle stages keep their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v     <= '0;
            c_r   <= '0;
            ovf_r <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        a_r[k] <= nxt_a[k];
                        b_r[k] <= src_b[k];
                        c_r[k] <= co_w[k];
                        if (k == STAGES - 1) begin
                            ovf_r <= co_w[k] ^ cm_w[k];
                        end
                    end
                end
            end
        end
    end

    assign bus.out_valid = v[STAGES-1];
    assign bus.sum       = a_r[STAGES-1];
    assign bus.c_out     = c_r[STAGES-1];
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: a 32/8 (four-stage) instance and a 16/16 (one-stage)
// instance. Drivers push expected results into queues as beats are accepted;
// monitors pop and compare whenever a result beat transfers.
module tb_pipe_adder;
    import pipe_adder_pkg::*;

    localparam int W  = 32;
    localparam int C  = 8;
    localparam int S  = W / C;
    localparam int W1 = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W))  bus32 ();
    pipe_adder_if #(.WIDTH(W1)) bus16 ();

    pipe_adder #(.WIDTH(W), .CHUNK(C)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    pipe_adder #(.WIDTH(W1), .CHUNK(W1)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    // ---------------- bookkeeping ----------------
    int passed = 0;
    int total  = 0;
    int n_out  = 0;
    int n_out16 = 0;
    int stalls = 0;
    logic [W+1:0]  exp_q[$];
    logic [W1+1:0] exp16_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W+1:0] exp;   // {c_out, ovf, sum}
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub,
                                input logic co, input logic ov, input logic [W-1:0] s);
        vec_t t;
        t.a = a; t.b = b; t.cin = cin; t.sub = sub; t.exp = {co, ov, s};
        return t;
    endfunction

    // Reference model for random beats: wide add plus the sign rule for overflow.
    function automatic logic [W+1:0] model32(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        logic         ov;
        bb   = sub ? ~b : b;
        ci   = sub ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ov, full[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    // Entered and left just after a rising edge.
    task automatic drive32(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input logic [W+1:0] e, output bit acc);
        bus32.in_valid = 1'b1;
        bus32.a = a; bus32.b = b; bus32.c_in = cin; bus32.sub = sub;
        @(negedge clk);
        acc = bus32.in_ready;
        if (acc) exp_q.push_back(e);
        @(posedge clk); #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W+1:0] e);
        bit acc;
        int tries;
        tries = 0;
        do begin
            drive32(a, b, cin, sub, e, acc);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) begin
            total++;
            $display("FAIL send32_timeout: in_ready stayed 0 for %0d cycles, expected 1", tries);
        end
        stalls += tries - 1;
    endtask

    task automatic send16(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic cin,
                          input logic sub, input logic [W1+1:0] e);
        int tries;
        tries = 0;
        bus16.in_valid = 1'b1;
        bus16.a = a; bus16.b = b; bus16.c_in = cin; bus16.sub = sub;
        forever begin
            @(negedge clk);
            tries++;
            if (bus16.in_ready) begin
                exp16_q.push_back(e);
                break;
            end
            if (tries >= 50) begin
                total++;
                $display("FAIL send16_timeout: in_ready stayed 0 for %0d cycles, expected 1", tries);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_drain32(output int lat);
        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain32_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus32.out_valid && bus32.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat32: got sum=%0h, expected no beat", bus32.sum);
                end else begin
                    e = exp_q.pop_front();
                    check("result32", {bus32.c_out, bus32.ovf, bus32.sum}, e);
                    n_out++;
                end
            end
        end
    end

    initial begin
        logic [W1+1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus16.out_valid && bus16.out_ready) begin
                if (exp16_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_beat16: got sum=%0h, expected no beat", bus16.sum);
                end else begin
                    e = exp16_q.pop_front();
                    check("result16", {bus16.c_out, bus16.ovf, bus16.sum}, e);
                    n_out16++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int accepted;
        int base;
        bit acc;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        vecs.push_back(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000));
        vecs.push_back(mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE));
        vecs.push_back(mk(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2345_678A));
        vecs.push_back(mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF));
        vecs.push_back(mk(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100));
        vecs.push_back(mk(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0100_0000));
        vecs.push_back(mk(32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000));
        vecs.push_back(mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001));
        vecs.push_back(mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000));

        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.c_in = 1'b0; bus32.sub = 1'b0;
        bus32.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.c_in = 1'b0; bus16.sub = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset state.
        #2;
        check("rst_out_valid", bus32.out_valid, 1'b0);
        check("rst_sum",       bus32.sum, 32'h0);
        check("rst_c_out",     bus32.c_out, 1'b0);
        check("rst_ovf",       bus32.ovf, 1'b0);
        check("rst_in_ready",  bus32.in_ready, 1'b1);
        check("rst_out_valid16", bus16.out_valid, 1'b0);
        check("rst_in_ready16",  bus16.in_ready, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beat: wrap-around and latency.
        send32(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].sub, vecs[0].exp);
        lat = 0;
        while (!bus32.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency32", lat + 1, S);
        wait_drain32(lat);

        // Back-to-back stream: remaining directed vectors then 100 random beats.
        stalls = 0;
        for (int i = 1; i < vecs.size(); i++)
            send32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send32(ra, rb, rc, rs, model32(ra, rb, rc, rs));
        end
        check("stream_stalls", stalls, 0);
        wait_drain32(lat);
        check("stream_drain_cycles", lat, S);
        check("stream_count", n_out, 110);

        // Backpressure: fill the pipe with out_ready low, hold, then release.
        bus32.out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            drive32(ra, rb, 1'b0, 1'(i % 2), model32(ra, rb, 1'b0, 1'(i % 2)), acc);
            if (acc) accepted++;
        end
        check("fill_accepted", accepted, S);
        check("fill_in_ready", bus32.in_ready, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("stall_out_valid", bus32.out_valid, 1'b1);
            check("stall_hold", {bus32.c_out, bus32.ovf, bus32.sum}, exp_q[0]);
            check("stall_in_ready", bus32.in_ready, 1'b0);
        end
        @(posedge clk); #1;
        base = n_out;
        bus32.out_ready = 1'b1;
        #1;
        check("release_in_ready", bus32.in_ready, 1'b1);
        wait_drain32(lat);
        check("release_count", n_out - base, S);

        // Reset with three beats in flight.
        for (int i = 1; i <= 3; i++)
            send32(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus32.out_valid, 1'b0);
        check("midrst_sum",       bus32.sum, 32'h0);
        check("midrst_c_out",     bus32.c_out, 1'b0);
        check("midrst_ovf",       bus32.ovf, 1'b0);
        check("midrst_in_ready",  bus32.in_ready, 1'b1);
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_hold_valid", bus32.out_valid, 1'b0);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("postrst_no_stale", bus32.out_valid, 1'b0);
        end
        @(posedge clk); #1;
        send32(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].sub, vecs[1].exp);
        wait_drain32(lat);

        // Single-stage instance.
        send16(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        lat = 0;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency16", lat + 1, 1);
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
        send16(16'h0003, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        lat = 0;
        while (exp16_q.size() != 0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("count16", n_out16, 4);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
